bcd_serial_sub: RTL and testbench
=================================

// Module: bcd_serial_sub
// PURPOSE
//  Multi-digit packed-BCD subtractor. Computes |a - b| and a sign flag, one digit per clock.
//  Complements the combinational BCD digit adder.
//  Used by the calculator/counter datapath wherever decimal decrement or difference is needed.
//  Start/done handshake; operands are latched at start; results hold until the next start.
// PARAMETERS
//  DIGITS  4  number of BCD digits per operand (>=1); bus width = 4*DIGITS
// PORTS
//  clk      in   1         single clock, rising-edge
//  rst_n    in   1         asynchronous active-low reset
//  start    in   1         request; sampled only in IDLE
//  a        in   4*DIGITS  minuend, packed BCD, digit 0 = a[3:0] (LSD)
//  b        in   4*DIGITS  subtrahend, packed BCD
//  busy     out  1         high in every state other than IDLE
//  done     out  1         one-cycle pulse when results are valid
//  diff     out  4*DIGITS  |a-b|, packed BCD
//  neg      out  1         1 when a < b
//  invalid  out  1         1 when any input digit > 9 (diff=0, neg=0)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=0, done=0, diff=0, neg=0, invalid=0.
//    Digit index, borrow and operand registers clear.
//  - FSM: IDLE -> CHECK -> SUB -> [NEG] -> DONE -> IDLE.
//  - IDLE, start=1: latch a and b, go to CHECK.
//  - CHECK (1 cycle): scan all latched digits.
//    - Any digit > 9: invalid=1, diff=0, neg=0, go to DONE.
//    - Otherwise: invalid=0, idx=0, borrow=0, go to SUB.
//  - SUB: one digit per cycle, LSD first.
//    - Compute a[idx] - b[idx] - borrow.
//    - If the raw result < 0: add 10 and set borrow_out=1.
//    - Write the digit into diff[idx] and advance idx.
//    - After digit DIGITS-1: final borrow=0 -> neg=0, go to DONE.
//    - Final borrow=1 -> neg=1, idx=0, borrow=0, go to NEG.
//  - NEG: ten's-complement the stored result, one digit per cycle, LSD first.
//    - Compute diff[idx] = 0 - diff[idx] - borrow, using the same digit cell.
//    - After digit DIGITS-1, go to DONE.
//  - DONE: done=1 for exactly one cycle, then IDLE.
//    - diff, neg and invalid hold until the next accepted start.
//  - Latency, start edge to done-high cycle:
//    - invalid input: 2 cycles
//    - a >= b: DIGITS+2 cycles
//    - a < b: 2*DIGITS+2 cycles
//  - start while busy=1 is ignored; it is not queued.
//  - a and b may change freely after the start edge.
//  - Accepting a new start clears invalid, zeroes diff and clears neg on the next edge.
//    Outputs are never partially stale at done.
//  - a == b gives diff=0, neg=0. There is no negative zero.
//  - Width rule: digit arithmetic uses 5-bit signed intermediates; the range is -10..9
//    before correction.
//  - Reset asserted mid-SUB/NEG aborts the operation; no done pulse is produced.
// STRUCTURE
//  - Shared package bcd_pkg:
//    - typedef bcd_digit_t (4 bits)
//    - localparam BCD_MAX = 4'd9, BCD_BASE = 5'd10
//    - state enum {IDLE, CHECK, SUB, NEG, DONE}
//  - One sub-module, bcd_fsub: combinational digit cell.
//    - Ports: a[3:0], b[3:0], bin -> d[3:0], bout.
//    - Instantiated once and shared by SUB and NEG; NEG drives a=0, b=diff[idx].
//  - Top level holds the FSM, idx counter ($clog2(DIGITS) bits, min 1), operand regs and diff reg.
// TESTING (DIGITS=4; every case checks busy/done timing and a single done pulse)
//  1. a=0042, b=0017 -> diff=0025, neg=0, invalid=0; done 6 cycles after start.
//  2. a=0017, b=0042 -> diff=0025, neg=1; done 10 cycles after start.
//  3. a=1000, b=0001 -> diff=0999, neg=0 (full borrow ripple).
//     Also a=0000, b=9999 -> diff=9999, neg=1.
//  4. a=00A0, b=0001 -> invalid=1, diff=0000, neg=0; done 2 cycles after start.
//     Then a=0005, b=0005 -> invalid=0, diff=0000, neg=0.
//  5. start pulsed again during SUB with a different a -> ignored; first result returned unchanged.
//  6. rst_n low during NEG -> all outputs 0 at once, no done pulse.
//     Next start after release computes correctly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD arithmetic blocks.
// Digits are 4-bit codes 0..9; anything above BCD_MAX is an invalid code.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_BASE = 5'd10;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SUB,
    NEG,
    DONE
  } bcd_state_t;

  function automatic logic digit_bad(input bcd_digit_t d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_fsub.sv
// Combinational single-digit BCD subtract cell: d = a - b - bin, wrapped into 0..9.
// bout flags that ten was borrowed from the next digit up.
module bcd_fsub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout
);

  logic signed [4:0] raw;

  // For valid digits raw spans -10..9, so the sign bit alone decides the borrow.
  always_comb begin
    raw  = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0000, bin});
    bout = raw[4];
    d    = raw[3:0] + (bout ? BCD_BASE[3:0] : 4'd0);
  end

endmodule

// File: rtl/bcd_serial_sub.sv
// Multi-digit packed-BCD subtractor: |a - b| plus sign, one digit per clock through one shared cell.
// A negative raw result is ten's-complemented in place during a second serial pass.
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                invalid,
  output bcd_state_t          state_dbg
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  // Handshake: start is sampled only while busy=0; a and b are captured on that edge and
  // may change afterwards. done is a one-cycle pulse; diff/neg/invalid hold until next accept.

  bcd_state_t    state, next_state;
  logic [W-1:0]  opa_q, opb_q, diff_q;
  logic [IW-1:0] idx_q;
  logic          borrow_q, neg_q, invalid_q;
  logic          any_bad;
  logic [IW+1:0] base;
  bcd_digit_t    cell_a, cell_b, cell_d;
  logic          cell_bout;

  assign base = {idx_q, 2'b00};

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_bad(opa_q[4*i +: 4]) || digit_bad(opb_q[4*i +: 4])) any_bad = 1'b1;
    end
  end

  // NEG reuses the cell as 0 - diff[idx] - borrow to complement the stored result.
  always_comb begin
    cell_a = (state == NEG) ? 4'd0 : opa_q[base +: 4];
    cell_b = (state == NEG) ? diff_q[base +: 4] : opb_q[base +: 4];
  end

  bcd_fsub u_fsub (
    .a    (cell_a),
    .b    (cell_b),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CHECK;
      CHECK:   next_state = any_bad ? DONE : SUB;
      SUB:     if (idx_q == LAST) next_state = cell_bout ? NEG : DONE;
      NEG:     if (idx_q == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q     <= '0;
      opb_q     <= '0;
      diff_q    <= '0;
      idx_q     <= '0;
      borrow_q  <= 1'b0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa_q     <= a;
            opb_q     <= b;
            diff_q    <= '0;
            neg_q     <= 1'b0;
            invalid_q <= 1'b0;
          end
        end
        CHECK: begin
          idx_q    <= '0;
          borrow_q <= 1'b0;
          if (any_bad) begin
            invalid_q <= 1'b1;
            diff_q    <= '0;
            neg_q     <= 1'b0;
          end
        end
        SUB: begin
          diff_q[base +: 4] <= cell_d;
          if (idx_q == LAST) begin
            idx_q    <= '0;
            borrow_q <= 1'b0;
            neg_q    <= cell_bout;
          end else begin
            idx_q    <= idx_q + IW'(1);
            borrow_q <= cell_bout;
          end
        end
        NEG: begin
          diff_q[base +: 4] <= cell_d;
          borrow_q          <= cell_bout;
          idx_q             <= (idx_q == LAST) ? '0 : idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign diff      = diff_q;
  assign neg       = neg_q;
  assign invalid   = invalid_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Directed and randomized bench for bcd_serial_sub against a decimal-integer reference model.
module tb_bcd_serial_sub;
  import bcd_pkg::*;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, neg, invalid;
  logic [W-1:0] diff;
  bcd_state_t   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  bcd_serial_sub #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .neg       (neg),
    .invalid   (invalid),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int to_int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic is_bad(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    return to_bcd(int'($urandom_range(0, 9999)));
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input bit poke_start);
    logic         exp_inv, exp_neg;
    logic [W-1:0] exp_diff;
    int           lat, cnt, ai, bi;
    bit           seen;
    exp_inv = is_bad(op_a) || is_bad(op_b);
    if (exp_inv) begin
      exp_diff = '0;
      exp_neg  = 1'b0;
      lat      = 2;
    end else begin
      ai       = to_int(op_a);
      bi       = to_int(op_b);
      exp_neg  = (ai < bi);
      exp_diff = to_bcd(exp_neg ? bi - ai : ai - bi);
      lat      = exp_neg ? 2 * D + 2 : D + 2;
    end
    exp_q.push_back(exp_diff);

    @(negedge clk);
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = rand_bcd();
    b = rand_bcd();
    cnt = 1;
    seen = 1'b0;
    check("accept_busy", W'(busy), W'(1'b1));
    check("accept_diff_cleared", diff, '0);
    check("accept_flags_cleared", W'({neg, invalid}), '0);

    while (!seen && cnt < 40) begin
      if (poke_start && cnt == 3) begin
        start = 1'b1;
        a = rand_bcd();
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cnt++;
      if (done) seen = 1'b1;
      else check("busy_while_running", W'(busy), W'(1'b1));
    end
    start = 1'b0;

    check("done_seen", W'(seen), W'(1'b1));
    check("latency", W'(cnt), W'(lat));
    check("busy_at_done", W'(busy), W'(1'b1));
    check("diff", diff, exp_q.pop_front());
    check("neg", W'(neg), W'(exp_neg));
    check("invalid", W'(invalid), W'(exp_inv));

    @(posedge clk);
    #1;
    check("done_single_pulse", W'(done), '0);
    check("idle_not_busy", W'(busy), '0);
    repeat (2) @(posedge clk);
    #1;
    check("hold_diff", diff, exp_diff);
    check("hold_neg", W'(neg), W'(exp_neg));
    check("hold_invalid", W'(invalid), W'(exp_inv));
  endtask

  task automatic reset_in_neg();
    int cnt;
    @(negedge clk);
    a = 16'h0017;
    b = 16'h0042;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 1;
    // With D=4 the sign pass starts after the 5th edge; strike midway through it.
    while (cnt < 7) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("pre_reset_in_neg", W'(state_dbg), W'(NEG));
    rst_n = 1'b0;
    #1;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_diff", diff, '0);
    check("rst_flags", W'({neg, invalid}), '0);
    check("rst_state", W'(state_dbg), W'(IDLE));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_done", W'(done), '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (D + 4) begin
      @(posedge clk);
      #1;
      check("post_abort_no_done", W'(done), '0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_diff", diff, '0);
    check("reset_flags", W'({neg, invalid}), '0);
    check("reset_state", W'(state_dbg), W'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h0042, 16'h0017, 1'b0);
    run_op(16'h0017, 16'h0042, 1'b0);
    run_op(16'h1000, 16'h0001, 1'b0);
    run_op(16'h0000, 16'h9999, 1'b0);
    run_op(16'h00A0, 16'h0001, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b0);
    run_op(16'h0042, 16'h0017, 1'b1);
    run_op(16'h0017, 16'h0042, 1'b1);
    reset_in_neg();
    run_op(16'h0123, 16'h0456, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = rand_bcd();
      rb = ($urandom_range(0, 7) == 0) ? ra : rand_bcd();
      run_op(ra, rb, ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 4; i++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if (i[0]) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      else      rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      run_op(ra, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
